// File: rtl/ram_xfer_sequencer.sv
// ram_xfer_sequencer
// Owns the single-port data RAM and the UART byte interface. Three clients share
// the RAM: the UART loader (PC->RAM), the UART dumper (RAM->PC) and the
// image-processing core. Whole-image transfers are sequenced from debounced
// command pulses; in PROC the RAM is handed to the core.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   cmd_load/dump/proc   1-cycle command pulses, honoured only in IDLE
//   cmd_idle             1-cycle abort pulse, honoured in every state
//   rx_done_tick/rx_data UART received byte
//   tx_start/tx_data     UART send request; tx_data held until next byte
//   tx_done_tick         UART finished sending
//   proc_*               processor RAM port, mirrored onto ram_* in PROC
//   proc_grant           processor owns the RAM
//   ram_*                single-port RAM interface (ram_rdata RD_LAT cycles late)
//   state                state encoding for LEDs (IDLE=0 .. PROC=5)
//   xfer_done            1-cycle pulse on completed load/dump/proc
//   busy                 state != IDLE
//   xfer_sum             (XFER_CHECKSUM_EN only) mod-256 sum of transferred bytes
//
// Optional feature macro: XFER_CHECKSUM_EN adds the xfer_sum output and its adder.
module ram_xfer_sequencer #(
  parameter int XFER_LEN = 16384,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_load,
  input  logic              cmd_dump,
  input  logic              cmd_proc,
  input  logic              cmd_idle,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done_tick,
  input  logic              proc_en,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_done,
  output logic              proc_grant,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        state,
  output logic              xfer_done,
  output logic              busy
`ifdef XFER_CHECKSUM_EN
  ,
  output logic [7:0]        xfer_sum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_DUMP_RD   = 3'd2,
    S_DUMP_WAIT = 3'd3,
    S_DUMP_TX   = 3'd4,
    S_PROC      = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(XFER_LEN - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wait_q, wait_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                done_q, done_d;
  logic                grant_q;
  logic                busy_q;

`ifdef XFER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  // Only the low byte of RAM data is ever sent over the UART.
  logic unused_rdata_hi;
  assign unused_rdata_hi = &{1'b0, ram_rdata[DATA_W-1:8]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    done_d      = 1'b0;
`ifdef XFER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_idle) begin
          state_d = S_IDLE;
        end else if (cmd_proc) begin
          state_d = S_PROC;
        end else if (cmd_dump) begin
          // The first read is issued in the DUMP_RD cycle itself.
          state_d    = S_DUMP_RD;
          addr_d     = '0;
          ram_en_d   = 1'b1;
          ram_addr_d = '0;
`ifdef XFER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end else if (cmd_load) begin
          state_d = S_LOAD;
          addr_d  = '0;
`ifdef XFER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      S_LOAD: begin
        if (rx_done_tick) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = DATA_W'(rx_data);
`ifdef XFER_CHECKSUM_EN
          sum_d       = sum8(sum_q, rx_data);
`endif
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      S_DUMP_RD: begin
        state_d = S_DUMP_WAIT;
        wait_d  = '0;
      end

      // Read data becomes valid in the RD_LAT-th wait cycle.
      S_DUMP_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          tx_data_d  = ram_rdata[7:0];
          tx_start_d = 1'b1;
          state_d    = S_DUMP_TX;
`ifdef XFER_CHECKSUM_EN
          sum_d      = sum8(sum_q, ram_rdata[7:0]);
`endif
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_DUMP_TX: begin
        if (tx_done_tick) begin
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d     = addr_q + ADDR_W'(1);
            ram_en_d   = 1'b1;
            ram_addr_d = addr_q + ADDR_W'(1);
            state_d    = S_DUMP_RD;
          end
        end
      end

      S_PROC: begin
        if (proc_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; whatever was in flight is dropped silently.
    if (cmd_idle) begin
      state_d    = S_IDLE;
      ram_en_d   = 1'b0;
      ram_we_d   = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
`ifdef XFER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wait_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef XFER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
      grant_q     <= (state_d == S_PROC);
      busy_q      <= (state_d != S_IDLE);
`ifdef XFER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // In PROC the core drives the RAM directly, without a register in the path.
  assign ram_en     = grant_q ? proc_en    : ram_en_q;
  assign ram_we     = grant_q ? proc_we    : ram_we_q;
  assign ram_addr   = grant_q ? proc_addr  : ram_addr_q;
  assign ram_wdata  = grant_q ? proc_wdata : ram_wdata_q;

  assign proc_grant = grant_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign xfer_done  = done_q;
  assign busy       = busy_q;
  assign state      = state_q;
`ifdef XFER_CHECKSUM_EN
  assign xfer_sum   = sum_q;
`endif

endmodule

// File: tb/tb_ram_xfer_sequencer.sv
module tb_ram_xfer_sequencer;

  localparam int XFER_LEN = 4;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_load = 1'b0, cmd_dump = 1'b0, cmd_proc = 1'b0, cmd_idle = 1'b0;
  logic              rx_done_tick = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done_tick = 1'b0;
  logic              proc_en = 1'b0, proc_we = 1'b0, proc_done = 1'b0;
  logic [ADDR_W-1:0] proc_addr = '0;
  logic [DATA_W-1:0] proc_wdata = '0;
  logic              proc_grant, ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [2:0]        state;
  logic              xfer_done, busy;
`ifdef XFER_CHECKSUM_EN
  logic [7:0]        xfer_sum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ram_xfer_sequencer #(
    .XFER_LEN(XFER_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_load(cmd_load), .cmd_dump(cmd_dump), .cmd_proc(cmd_proc), .cmd_idle(cmd_idle),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
    .proc_en(proc_en), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_done(proc_done), .proc_grant(proc_grant),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .state(state), .xfer_done(xfer_done), .busy(busy)
`ifdef XFER_CHECKSUM_EN
    , .xfer_sum(xfer_sum)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data RD_LAT cycles after the enable edge.
  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] rd_p0 = '0, rd_p1 = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        rd_p0 <= mem[ram_addr[7:0]];
    end
    rd_p1 <= rd_p0;
  end
  assign ram_rdata = (RD_LAT == 1) ? rd_p0 : rd_p1;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [48:0] all_outputs();
    return {state, busy, tx_start, ram_en, ram_we, proc_grant, xfer_done,
            ram_addr, ram_wdata, tx_data};
  endfunction

  task automatic test_reset();
    step();
    n_checks++;
    if (all_outputs() !== '0) $display("FAIL reset_outputs: got %h required 0", all_outputs());
    else n_pass++;
`ifdef XFER_CHECKSUM_EN
    n_checks++;
    if (xfer_sum !== 8'h00) $display("FAIL reset_sum: got %h required 00", xfer_sum);
    else n_pass++;
`endif
    reset = 1'b0;
    step();
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL idle_after_reset: state %0d busy %b required 0 0", state, busy);
    else n_pass++;
  endtask

  // Loads bytes, compares every observed RAM write with the scoreboard queue.
  task automatic run_load(input logic [7:0] bytes [4], output int done_cnt);
    logic [31:0] exp_wr [$];
    logic [31:0] e;
    int          missing = 0;
    done_cnt = 0;
    cmd_load = 1'b1;
    step();
    cmd_load = 1'b0;
    n_checks++;
    if (state !== 3'd1 || busy !== 1'b1) $display("FAIL load_enter: state %0d busy %b required 1 1", state, busy);
    else n_pass++;
    for (int i = 0; i < XFER_LEN; i++) begin
      exp_wr.push_back({16'(i), 8'h00, bytes[i]});
      rx_data = bytes[i];
      rx_done_tick = 1'b1;
      step();
      rx_done_tick = 1'b0;
      if (xfer_done) done_cnt++;
      if (ram_en && ram_we) begin
        e = exp_wr.pop_front();
        n_checks++;
        if ({ram_addr, ram_wdata} !== e) $display("FAIL load_write%0d: got %h required %h", i, {ram_addr, ram_wdata}, e);
        else n_pass++;
      end else missing++;
      for (int g = 0; g < 2; g++) begin
        step();
        if (xfer_done) done_cnt++;
        if (ram_en) missing++;
      end
    end
    n_checks++;
    if (missing != 0 || exp_wr.size() != 0) $display("FAIL load_write_count: stray/missing %0d left %0d required 0 0", missing, exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_load();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int done_cnt;
    int stray = 0;
    run_load(b, done_cnt);
    n_checks++;
    if (done_cnt != 1 || state !== 3'd0 || busy !== 1'b0) $display("FAIL load_done: pulses %0d state %0d busy %b required 1 0 0", done_cnt, state, busy);
    else n_pass++;
    for (int i = 0; i < XFER_LEN; i++) begin
      n_checks++;
      if (mem[i] !== {8'h00, b[i]}) $display("FAIL load_ram%0d: got %h required %h", i, mem[i], {8'h00, b[i]});
      else n_pass++;
    end
    // A fifth byte after completion must not be written.
    rx_data = 8'h99;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ram_en || state !== 3'd0) stray++;
      step();
    end
    n_checks++;
    if (stray != 0 || mem[4] === 16'h0099) $display("FAIL load_extra_byte: stray cycles %0d required 0", stray);
    else n_pass++;
  endtask

  task automatic test_dump();
    logic [7:0] exp_tx [$];
    logic [7:0] e;
    logic [7:0] held = '0;
    int sent = 0, done_cnt = 0, pending = 0, wait_cnt = 0;
    int overlap = 0, unstable = 0, saw_load = 0, wrote = 0;
    bit injected = 0;
    for (int i = 0; i < XFER_LEN; i++) begin
      mem[i] = {8'hA5, 8'(8'h11 * (i + 1))};
      exp_tx.push_back(8'(8'h11 * (i + 1)));
    end
    cmd_dump = 1'b1;
    cmd_load = 1'b1;
    step();
    cmd_dump = 1'b0;
    cmd_load = 1'b0;
    n_checks++;
    if (state !== 3'd2 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'd0)
      $display("FAIL dump_priority: state %0d en %b we %b addr %0d required 2 1 0 0", state, ram_en, ram_we, ram_addr);
    else n_pass++;
    for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
      step();
      tx_done_tick = 1'b0;
      cmd_load = 1'b0;
      if (xfer_done) done_cnt++;
      if (state === 3'd1) saw_load++;
      if (ram_we) wrote++;
      if (tx_start) begin
        if (pending != 0) overlap++;
        n_checks++;
        if (exp_tx.size() == 0) $display("FAIL dump_extra_tx: got %h required none", tx_data);
        else begin
          e = exp_tx.pop_front();
          if (tx_data !== e) $display("FAIL dump_tx%0d: got %h required %h", sent, tx_data, e);
          else n_pass++;
        end
        held = tx_data;
        pending = 1;
        wait_cnt = 4;
        sent++;
      end else if (pending != 0) begin
        if (tx_data !== held) unstable++;
        wait_cnt--;
        if (wait_cnt == 0) begin
          tx_done_tick = 1'b1;
          pending = 0;
        end
      end
      if (sent == 2 && !injected) begin
        cmd_load = 1'b1;
        injected = 1;
      end
    end
    step();
    n_checks++;
    if (sent != XFER_LEN || exp_tx.size() != 0 || done_cnt != 1)
      $display("FAIL dump_count: sent %0d left %0d done %0d required %0d 0 1", sent, exp_tx.size(), done_cnt, XFER_LEN);
    else n_pass++;
    n_checks++;
    if (overlap != 0 || unstable != 0 || saw_load != 0 || wrote != 0 || state !== 3'd0)
      $display("FAIL dump_protocol: overlap %0d unstable %0d load %0d writes %0d state %0d required all 0", overlap, unstable, saw_load, wrote, state);
    else n_pass++;
  endtask

  task automatic test_proc();
    // Processor port is ignored outside PROC.
    proc_en = 1'b1;
    proc_we = 1'b1;
    proc_addr = 16'd7;
    proc_wdata = 16'h1234;
    #1;
    n_checks++;
    if (ram_en !== 1'b0 || proc_grant !== 1'b0) $display("FAIL proc_ignored: en %b grant %b required 0 0", ram_en, proc_grant);
    else n_pass++;
    proc_en = 1'b0;
    proc_we = 1'b0;
    cmd_proc = 1'b1;
    step();
    cmd_proc = 1'b0;
    n_checks++;
    if (proc_grant !== 1'b1 || state !== 3'd5 || busy !== 1'b1) $display("FAIL proc_enter: grant %b state %0d required 1 5", proc_grant, state);
    else n_pass++;
    proc_en = 1'b1;
    proc_we = 1'b1;
    proc_wdata = 16'hBEEF;
    #1;
    n_checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'd7, 16'hBEEF})
      $display("FAIL proc_mirror: got %h required %h", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 16'd7, 16'hBEEF});
    else n_pass++;
    step();
    proc_en = 1'b0;
    proc_we = 1'b0;
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    n_checks++;
    if (xfer_done !== 1'b1 || proc_grant !== 1'b0 || state !== 3'd0 || mem[7] !== 16'hBEEF)
      $display("FAIL proc_done: done %b grant %b state %0d ram7 %h required 1 0 0 beef", xfer_done, proc_grant, state, mem[7]);
    else n_pass++;
    step();
    n_checks++;
    if (xfer_done !== 1'b0) $display("FAIL proc_done_pulse: got %b required 0", xfer_done);
    else n_pass++;
  endtask

  task automatic test_abort();
    int seen = 0, stray = 0;
    cmd_dump = 1'b1;
    step();
    cmd_dump = 1'b0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      step();
      if (tx_start) seen = 1;
    end
    n_checks++;
    if (seen == 0) $display("FAIL abort_tx_timeout: no tx_start within 20 cycles");
    else n_pass++;
    cmd_idle = 1'b1;
    step();
    cmd_idle = 1'b0;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL abort_idle: state %0d busy %b required 0 0", state, busy);
    else n_pass++;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (xfer_done || tx_start || ram_en) stray++;
      step();
    end
    // Abort from PROC drops the grant without a done pulse.
    cmd_proc = 1'b1;
    step();
    cmd_proc = 1'b0;
    cmd_idle = 1'b1;
    proc_done = 1'b1;
    step();
    cmd_idle = 1'b0;
    proc_done = 1'b0;
    if (xfer_done || proc_grant || state !== 3'd0) stray++;
    n_checks++;
    if (stray != 0) $display("FAIL abort_quiet: stray events %0d required 0", stray);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    cmd_load = 1'b1;
    step();
    cmd_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_data = 8'(8'hC0 + i);
      rx_done_tick = 1'b1;
      step();
      rx_done_tick = 1'b0;
    end
    // Reset lands between clock edges and must take effect at once.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (all_outputs() !== '0) $display("FAIL reset_mid_load: got %h required 0", all_outputs());
    else n_pass++;
    step();
    reset = 1'b0;
    cmd_load = 1'b1;
    step();
    cmd_load = 1'b0;
    rx_data = 8'h5A;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    n_checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'd0, 16'h005A})
      $display("FAIL reload_addr0: got %h required %h", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 16'd0, 16'h005A});
    else n_pass++;
    cmd_idle = 1'b1;
    step();
    cmd_idle = 1'b0;
  endtask

`ifdef XFER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b [4] = '{8'hFF, 8'h02, 8'h10, 8'h01};
    int done_cnt;
    run_load(b, done_cnt);
    n_checks++;
    if (done_cnt != 1 || xfer_sum !== 8'h12) $display("FAIL checksum_load: sum %h done %0d required 12 1", xfer_sum, done_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_load();
    test_dump();
    test_proc();
    test_abort();
    test_reset_mid_load();
`ifdef XFER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
